// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 read-side engine.
// Timing defaults assume a 50 MHz clock: 2 + 25 + 2 + 21 cycles = 1 us per bus cycle.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EN_HI,
    ST_HOLD,
    ST_GAP,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int DEF_T_SETUP   = 2;
  localparam int DEF_T_EN_HIGH = 25;
  localparam int DEF_T_HOLD    = 2;
  localparam int DEF_T_GAP     = 21;
  localparam int DEF_POLL_MAX  = 2000;

  localparam logic LCD_RS_CMD  = 1'b0;
  localparam logic LCD_RS_DATA = 1'b1;

  localparam int BF_BIT = 7;

  // Width that holds the largest phase length.
  function automatic int phase_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lcd_reader_if.sv
// Request/response and LCD pin bundle between the read engine and its user.
// Handshake: iSTART is a one-cycle request taken only while oBUSY = 0; oDONE pulses once per accepted request.
interface lcd_reader_if;

  logic                 iSTART;
  logic                 iMODE;
  logic                 iWAIT_READY;
  logic [7:0]           iLCD_DATA;
  logic                 oBUSY;
  logic                 oDONE;
  logic [7:0]           oDATA;
  logic                 oBF;
  logic [6:0]           oADDR;
  logic                 oTIMEOUT;
  logic                 oRD_ACTIVE;
  logic                 LCD_RW;
  logic                 LCD_RS;
  logic                 LCD_EN;
  lcd_pkg::state_t      state;

  modport master (
    output iSTART, iMODE, iWAIT_READY, iLCD_DATA,
    input  oBUSY, oDONE, oDATA, oBF, oADDR, oTIMEOUT, oRD_ACTIVE,
    input  LCD_RW, LCD_RS, LCD_EN, state
  );

  modport slave (
    input  iSTART, iMODE, iWAIT_READY, iLCD_DATA,
    output oBUSY, oDONE, oDATA, oBF, oADDR, oTIMEOUT, oRD_ACTIVE,
    output LCD_RW, LCD_RS, LCD_EN, state
  );

endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter; tc is high in the last cycle of a phase loaded with length-1.
module lcd_phase_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/lcd_reader.sv
// HD44780 read engine: status or data reads with EN timing, optional busy-flag polling.
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int T_SETUP   = DEF_T_SETUP,
    parameter int T_EN_HIGH = DEF_T_EN_HIGH,
    parameter int T_HOLD    = DEF_T_HOLD,
    parameter int T_GAP     = DEF_T_GAP,
    parameter int POLL_MAX  = DEF_POLL_MAX
) (
    input  logic          iCLK,
    input  logic          iRST,
    lcd_reader_if.slave   bus
);

    localparam int CW = phase_width(T_SETUP, T_EN_HIGH, T_HOLD, T_GAP);
    localparam int PW = $clog2(POLL_MAX + 1);
    localparam logic [PW-1:0] POLL_LIM = PW'(POLL_MAX);

    state_t        state;
    logic          mode_q, wait_q;
    logic [PW-1:0] poll_cnt;
    logic          busy, done, bf, timeout, rd_active, rw, rs, en;
    logic [7:0]    data_q;
    logic [6:0]    addr;

    logic          tc, load;
    logic [CW-1:0] load_val;
    logic [PW-1:0] poll_next;
    logic          poll_again;

    // CHECK sees the count after this read has been counted.
    assign poll_next  = poll_cnt + PW'(1);
    assign poll_again = wait_q && bf && (poll_next < POLL_LIM);

    always_comb begin
        load     = 1'b0;
        load_val = '0;
        case (state)
            ST_IDLE:  if (bus.iSTART) begin load = 1'b1; load_val = CW'(T_SETUP - 1);   end
            ST_SETUP: if (tc)         begin load = 1'b1; load_val = CW'(T_EN_HIGH - 1); end
            ST_EN_HI: if (tc)         begin load = 1'b1; load_val = CW'(T_HOLD - 1);    end
            ST_HOLD:  if (tc)         begin load = 1'b1; load_val = CW'(T_GAP - 1);     end
            ST_CHECK: if (poll_again) begin load = 1'b1; load_val = CW'(T_SETUP - 1);   end
            default:  ;
        endcase
    end

    lcd_phase_timer #(.W(CW)) u_timer (
        .clk   (iCLK),
        .rst   (iRST),
        .load  (load),
        .value (load_val),
        .tc    (tc)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= ST_IDLE;
            mode_q    <= 1'b0;
            wait_q    <= 1'b0;
            poll_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            data_q    <= 8'h00;
            bf        <= 1'b1;
            addr      <= 7'h00;
            timeout   <= 1'b0;
            rd_active <= 1'b0;
            rw        <= 1'b0;
            rs        <= 1'b0;
            en        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (bus.iSTART) begin
                    state     <= ST_SETUP;
                    mode_q    <= bus.iMODE;
                    wait_q    <= bus.iWAIT_READY & ~bus.iMODE;
                    poll_cnt  <= '0;
                    timeout   <= 1'b0;
                    busy      <= 1'b1;
                    rd_active <= 1'b1;
                    rw        <= 1'b1;
                    rs        <= bus.iMODE ? LCD_RS_DATA : LCD_RS_CMD;
                    en        <= 1'b0;
                end
                ST_SETUP: if (tc) begin
                    state <= ST_EN_HI;
                    en    <= 1'b1;
                end
                ST_EN_HI: if (tc) begin
                    state  <= ST_HOLD;
                    en     <= 1'b0;
                    data_q <= bus.iLCD_DATA;
                    if (mode_q == LCD_RS_CMD) begin
                        bf   <= bus.iLCD_DATA[BF_BIT];
                        addr <= bus.iLCD_DATA[6:0];
                    end
                end
                ST_HOLD: if (tc) state <= ST_GAP;
                ST_GAP: if (tc) begin
                    state     <= ST_CHECK;
                    rd_active <= 1'b0;
                end
                ST_CHECK: begin
                    if (poll_cnt != POLL_LIM) poll_cnt <= poll_next;
                    if (poll_again) begin
                        state     <= ST_SETUP;
                        rd_active <= 1'b1;
                    end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        rw    <= 1'b0;
                        rs    <= 1'b0;
                        if (wait_q && bf) timeout <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.oBUSY      = busy;
    assign bus.oDONE      = done;
    assign bus.oDATA      = data_q;
    assign bus.oBF        = bf;
    assign bus.oADDR      = addr;
    assign bus.oTIMEOUT   = timeout;
    assign bus.oRD_ACTIVE = rd_active;
    assign bus.LCD_RW     = rw;
    assign bus.LCD_RS     = rs;
    assign bus.LCD_EN     = en;
    assign bus.state      = state;

endmodule

// File: tb/tb_lcd_reader.sv
// Bench for lcd_reader: LCD response model, spec-level reference model, directed and random reads.
module tb_lcd_reader;
  import lcd_pkg::*;

  localparam int T_SUM = DEF_T_SETUP + DEF_T_EN_HIGH + DEF_T_HOLD + DEF_T_GAP;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  lcd_reader_if bus_a ();
  lcd_reader_if bus_b ();

  lcd_reader u_dut (.iCLK(clk), .iRST(rst), .bus(bus_a));
  lcd_reader #(.POLL_MAX(4)) u_dut_to (.iCLK(clk), .iRST(rst), .bus(bus_b));

  int tests = 0;
  int fails = 0;

  // LCD model: each EN rising edge presents the next queued byte; an empty queue keeps the last byte.
  logic [7:0] rsp_a[$];
  logic [7:0] rsp_b[$];
  logic [7:0] exp_q[$];
  int pulses_a = 0, pulses_b = 0;
  int en_run_a = 0, en_len_a = 0;
  int rs_bad_a = 0;
  logic exp_rs_a = 1'b0;

  always @(posedge bus_a.LCD_EN) begin
    pulses_a++;
    if (rsp_a.size() > 0) bus_a.iLCD_DATA = rsp_a.pop_front();
  end

  always @(posedge bus_b.LCD_EN) begin
    pulses_b++;
    if (rsp_b.size() > 0) bus_b.iLCD_DATA = rsp_b.pop_front();
  end

  always @(negedge clk) begin
    if (bus_a.LCD_EN === 1'b1) en_run_a++;
    else if (en_run_a != 0) begin
      en_len_a = en_run_a;
      en_run_a = 0;
    end
    if (bus_a.oRD_ACTIVE === 1'b1 && (bus_a.LCD_RS !== exp_rs_a || bus_a.LCD_RW !== 1'b1))
      rs_bad_a++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: repeat reads while waiting and busy, up to pmax reads; each read costs T_SUM+1 cycles, plus DONE.
  function automatic void model(input logic mode, input logic wt, input int pmax,
                                input logic [7:0] rsp[$], inout logic bf_m, inout logic [6:0] addr_m,
                                output logic [7:0] data_m, output int reads, output logic to_m);
    logic weff;
    logic [7:0] v;
    weff = wt & ~mode;
    reads = 0;
    data_m = 8'h00;
    do begin
      v = (reads < rsp.size()) ? rsp[reads] : rsp[rsp.size() - 1];
      reads++;
      data_m = v;
      if (!mode) begin
        bf_m = v[7];
        addr_m = v[6:0];
      end
    end while (weff && bf_m && reads < pmax);
    to_m = weff && bf_m;
  endfunction

  task automatic set_start(input bit sel, input logic s, input logic m, input logic w);
    if (sel) begin
      bus_b.iSTART = s; bus_b.iMODE = m; bus_b.iWAIT_READY = w;
    end else begin
      bus_a.iSTART = s; bus_a.iMODE = m; bus_a.iWAIT_READY = w;
    end
  endtask

  // Pulses iSTART, optionally re-pulses it at cycle extra_at, returns the cycle of oDONE (-1 on budget expiry).
  task automatic run(input bit sel, input logic mode, input logic wt, input int extra_at,
                     output int lat, output logic busy_ok);
    int n;
    @(posedge clk); #1;
    if (!sel) exp_rs_a = mode;
    set_start(sel, 1'b1, mode, wt);
    n = 0;
    lat = -1;
    busy_ok = 1'b1;
    while (n < 3000 && lat < 0) begin
      @(posedge clk); #1;
      n++;
      set_start(sel, (n == extra_at), mode, wt);
      if ((sel ? bus_b.oBUSY : bus_a.oBUSY) !== 1'b1) busy_ok = 1'b0;
      if ((sel ? bus_b.oDONE : bus_a.oDONE) === 1'b1) lat = n;
    end
    if (lat < 0) check("done_within_budget", 32'(n), 32'(0));
  endtask

  logic       m_bf = 1'b1;
  logic [6:0] m_addr = 7'h00;
  logic [7:0] m_data;
  logic       m_to, busy_ok, done_seen, r_mode, r_wt;
  logic [7:0] lst[$];
  int         m_reads, lat, p0, nb;

  initial begin
    set_start(1'b0, 1'b0, 1'b0, 1'b0);
    set_start(1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus_a.oBUSY), 32'(0));
    check("rst_done", 32'(bus_a.oDONE), 32'(0));
    check("rst_bf", 32'(bus_a.oBF), 32'(1));
    check("rst_outs", {bus_a.oDATA, 1'b0, bus_a.oADDR, 12'h0, bus_a.oTIMEOUT,
                       bus_a.oRD_ACTIVE, bus_a.LCD_RW, bus_a.LCD_RS}, 32'(0));
    check("rst_en", 32'(bus_a.LCD_EN), 32'(0));
    check("rst_state", 32'(bus_a.state), 32'(ST_IDLE));
    rst = 1'b0;

    // Status read
    rsp_a.push_back(8'h25);
    p0 = pulses_a;
    run(1'b0, 1'b0, 1'b0, 0, lat, busy_ok);
    check("status_lat", 32'(lat), 32'(52));
    check("status_busy", 32'(busy_ok), 32'(1));
    check("status_data", 32'(bus_a.oDATA), 32'h25);
    check("status_bf", 32'(bus_a.oBF), 32'(0));
    check("status_addr", 32'(bus_a.oADDR), 32'h25);
    check("status_pulses", 32'(pulses_a - p0), 32'(1));
    check("status_en_len", 32'(en_len_a), 32'(DEF_T_EN_HIGH));
    m_bf = 1'b0; m_addr = 7'h25;
    @(posedge clk); #1;
    check("status_busy_after", 32'(bus_a.oBUSY), 32'(0));

    // Data read
    rsp_a.push_back(8'h48);
    run(1'b0, 1'b1, 1'b0, 0, lat, busy_ok);
    check("data_lat", 32'(lat), 32'(52));
    check("data_data", 32'(bus_a.oDATA), 32'h48);
    check("data_bf_addr", {bus_a.oBF, bus_a.oADDR}, {m_bf, m_addr});
    check("data_rs_rw", 32'(rs_bad_a), 32'(0));

    // Random reads against the reference model
    for (int it = 0; it < 8; it++) begin
      r_mode = 1'($urandom_range(0, 1));
      r_wt = 1'($urandom_range(0, 1));
      nb = (r_wt && !r_mode) ? int'($urandom_range(0, 3)) : 0;
      lst.delete();
      for (int k = 0; k < nb; k++) lst.push_back(8'h80 | 8'($urandom_range(0, 127)));
      lst.push_back(r_mode ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 127)));
      foreach (lst[k]) rsp_a.push_back(lst[k]);
      model(r_mode, r_wt, DEF_POLL_MAX, lst, m_bf, m_addr, m_data, m_reads, m_to);
      exp_q.push_back(m_data);
      p0 = pulses_a;
      run(1'b0, r_mode, r_wt, 0, lat, busy_ok);
      check("rand_lat", 32'(lat), 32'(m_reads * (T_SUM + 1) + 1));
      check("rand_data", 32'(bus_a.oDATA), 32'(exp_q.pop_front()));
      check("rand_bf_addr_to", {bus_a.oBF, bus_a.oADDR, bus_a.oTIMEOUT}, {m_bf, m_addr, m_to});
      check("rand_pulses", 32'(pulses_a - p0), 32'(m_reads));
    end

    // Wait mode: three busy reads, then ready with address 07
    lst.delete();
    lst.push_back(8'hA0); lst.push_back(8'h9F); lst.push_back(8'hFF); lst.push_back(8'h07);
    foreach (lst[k]) rsp_a.push_back(lst[k]);
    model(1'b0, 1'b1, DEF_POLL_MAX, lst, m_bf, m_addr, m_data, m_reads, m_to);
    p0 = pulses_a;
    run(1'b0, 1'b0, 1'b1, 0, lat, busy_ok);
    check("wait_lat", 32'(lat), 32'(205));
    check("wait_pulses", 32'(pulses_a - p0), 32'(4));
    check("wait_addr", 32'(bus_a.oADDR), 32'h07);
    check("wait_timeout", 32'(bus_a.oTIMEOUT), 32'(m_to));

    // Timeout: POLL_MAX = 4 with BF stuck high
    rsp_b.push_back(8'hC3);
    p0 = pulses_b;
    run(1'b1, 1'b0, 1'b1, 0, lat, busy_ok);
    check("to_pulses", 32'(pulses_b - p0), 32'(4));
    check("to_lat", 32'(lat), 32'(4 * (T_SUM + 1) + 1));
    check("to_flag", 32'(bus_b.oTIMEOUT), 32'(1));
    check("to_bf_addr", {bus_b.oBF, bus_b.oADDR}, {1'b1, 7'h43});

    // Start re-pulsed during EN_HI is ignored
    rsp_a.push_back(8'h3C);
    p0 = pulses_a;
    run(1'b0, 1'b0, 1'b0, 10, lat, busy_ok);
    check("ignore_lat", 32'(lat), 32'(52));
    repeat (60) @(posedge clk);
    #1;
    check("ignore_pulses", 32'(pulses_a - p0), 32'(1));
    check("ignore_idle", 32'(bus_a.oBUSY), 32'(0));

    // Reset in cycle 10
    rsp_a.push_back(8'h11);
    exp_rs_a = 1'b0;
    done_seen = 1'b0;
    @(posedge clk); #1;
    set_start(1'b0, 1'b1, 1'b0, 1'b0);
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      set_start(1'b0, 1'b0, 1'b0, 1'b0);
      if (bus_a.oDONE === 1'b1) done_seen = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_en", 32'(bus_a.LCD_EN), 32'(0));
    check("abort_rd_active", 32'(bus_a.oRD_ACTIVE), 32'(0));
    check("abort_state_bf", {bus_a.state, bus_a.oBF, bus_a.oBUSY}, {ST_IDLE, 1'b1, 1'b0});
    rst = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (bus_a.oDONE === 1'b1) done_seen = 1'b1;
    end
    check("abort_no_done", 32'(done_seen), 32'(0));
    rsp_a.push_back(8'h5A);
    run(1'b0, 1'b0, 1'b0, 0, lat, busy_ok);
    check("after_abort_lat", 32'(lat), 32'(52));
    check("after_abort_data", {bus_a.oDATA, bus_a.oBF, bus_a.oADDR}, {8'h5A, 1'b0, 7'h5A});
    check("rs_rw_overall", 32'(rs_bad_a), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
